csr_trap_ctrl_ysyx_23060136: RTL
================================

CSR_TRAP_CTRL_YSYX_23060136 -- requirements
Module: csr_trap_ctrl_ysyx_23060136

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter: CAUSE_ECALL, default 32'd11, mcause value written on ECALL.
REQ-003 Port: clk  in  1  system clock, rising edge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: req_valid  in  1  trap request from EXU.
REQ-006 Port: req_op  in  2  01=ECALL, 10=MRET, 00/11=illegal.
REQ-007 Port: req_pc  in  32  PC of the trapping instruction.
REQ-008 Port: req_ready  out  1  controller can accept a request.
REQ-009 Port: req_err  out  1  one-cycle pulse, illegal op dropped.
REQ-010 Port: csr_rd_idx  out  2  CSR read index, using the shared `mstatus/`mtvec/`mepc/`mcause encodings.
REQ-011 Port: csr_rd_data  in  32  combinational read data for csr_rd_idx.
REQ-012 Port: csr_wr_en / csr_wr_idx / csr_wr_data  out  1/2/32  single CSR write port.
REQ-013 Port: redirect_valid  out  1  fetch redirect request.
REQ-014 Port: redirect_pc  out  32  redirect target.
REQ-015 Port: redirect_ready  in  1  IFU accepts redirect.
REQ-016 Port: busy  out  1  high in every state except IDLE; pipeline flush/stall.

Function
REQ-017 FSM states SHALL be IDLE, E_MEPC, E_MCAUSE, E_MSTAT, M_MEPC, M_MSTAT, REDIR.
REQ-018 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready at a rising edge, latching req_op and req_pc.
REQ-019 Accepted ECALL: IDLE->E_MEPC->E_MCAUSE->E_MSTAT->REDIR, one state per cycle.
REQ-020 Accepted MRET: IDLE->M_MEPC->M_MSTAT->REDIR.
REQ-021 Accepted illegal op: stay IDLE, pulse req_err for the cycle after acceptance, no CSR write, no redirect.
REQ-022 E_MEPC: csr_wr_en=1, idx=`mepc, data={req_pc[31:2],2'b00}.
REQ-023 E_MCAUSE: write `mcause=CAUSE_ECALL; csr_rd_idx=`mtvec; latch target={csr_rd_data[31:2],2'b00} (direct mode).
REQ-024 E_MSTAT: csr_rd_idx=`mstatus; write `mstatus = read value with bit7(MPIE)=bit3(MIE), bit3=0, bits[12:11](MPP)=2'b11.
REQ-025 M_MEPC: csr_rd_idx=`mepc; latch target={csr_rd_data[31:2],2'b00}; no write.
REQ-026 M_MSTAT: csr_rd_idx=`mstatus; write `mstatus with bit3=old bit7, bit7=1, bits[12:11]=2'b11.
REQ-027 REDIR: redirect_valid=1, redirect_pc=latched target, both held stable until redirect_ready=1; on that edge return to IDLE.
REQ-028 csr_wr_en SHALL be 0 outside E_MEPC, E_MCAUSE, E_MSTAT, M_MSTAT; at most one write per cycle.
REQ-029 csr_rd_idx SHALL default to `mstatus when not listed above; csr_wr_idx/data SHALL be 0 when csr_wr_en=0.
REQ-030 Latency: ECALL redirect_valid first high 4 cycles after acceptance edge; MRET 3 cycles.
REQ-031 req_valid while busy SHALL be ignored (not latched, no req_err); requester holds it.
REQ-032 redirect_ready while not in REDIR SHALL have no effect.
REQ-033 redirect_ready tied high: REDIR lasts exactly one cycle; a new request is acceptable the next cycle.

Reset
REQ-034 rst_n=0 SHALL force IDLE immediately: req_ready=1, busy=0, req_err=0, csr_wr_en=0, redirect_valid=0, redirect_pc=0, latched pc/target/op=0.
REQ-035 Reset mid-sequence SHALL abort without further CSR writes; writes already issued are not undone.

Verification
REQ-036 ECALL pc=0x8000_0104, mtvec=0x8000_1003, mstatus=0x0000_0008, redirect_ready=1 -> writes mepc=0x8000_0104, mcause=11, mstatus=0x0000_1880; redirect_pc=0x8000_1000 4 cycles after accept.
REQ-037 MRET, mepc=0x8000_0106, mstatus=0x0000_1880 -> mstatus write 0x0000_1888; redirect_pc=0x8000_0104 3 cycles after accept.
REQ-038 ECALL with redirect_ready low 5 cycles -> redirect_valid/pc stable 5 cycles, busy high, req_ready low; IDLE after ready edge.
REQ-039 req_op=2'b11 -> req_err one cycle, no csr_wr_en, no redirect_valid, req_ready stays 1.
REQ-040 rst_n low during E_MCAUSE -> next cycle no csr_wr_en, busy=0, redirect_valid=0; subsequent MRET runs normally.
REQ-041 Second ECALL held valid during first sequence -> accepted only in IDLE after first REDIR; exactly 3 writes per ECALL.

Source files
------------

// File: rtl/csr_trap_ctrl_ysyx_23060136.sv
// Trap sequencer for ECALL/MRET: walks the CSR updates one write per cycle,
// then holds a fetch redirect until the IFU takes it.
`ifndef MSTATUS
`define MSTATUS 2'd0
`define MTVEC   2'd1
`define MEPC    2'd2
`define MCAUSE  2'd3
`endif

module csr_trap_ctrl_ysyx_23060136 #(
    parameter logic [31:0] CAUSE_ECALL = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        req_err,
    output logic [1:0]  csr_rd_idx,
    input  logic [31:0] csr_rd_data,
    output logic        csr_wr_en,
    output logic [1:0]  csr_wr_idx,
    output logic [31:0] csr_wr_data,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] E_MEPC   = 3'd1;
    localparam logic [2:0] E_MCAUSE = 3'd2;
    localparam logic [2:0] E_MSTAT  = 3'd3;
    localparam logic [2:0] M_MEPC   = 3'd4;
    localparam logic [2:0] M_MSTAT  = 3'd5;
    localparam logic [2:0] REDIR    = 3'd6;

    localparam logic [1:0] OP_ECALL = 2'b01;
    localparam logic [1:0] OP_MRET  = 2'b10;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] pc;
    } trap_req_t;

    logic [2:0]  state, state_nxt;
    trap_req_t   req_q;
    logic [31:0] target_q;
    logic        err_q;
    logic        accept;
    logic        unused_req_bits;

    assign req_ready       = (state == IDLE);
    assign busy            = (state != IDLE);
    assign accept          = req_valid && req_ready;
    assign req_err         = err_q;
    assign redirect_valid  = (state == REDIR);
    assign redirect_pc     = target_q;
    assign unused_req_bits = ^{req_q.op, req_q.pc[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && req_op == OP_ECALL) state_nxt = E_MEPC;
                else if (accept && req_op == OP_MRET) state_nxt = M_MEPC;
            end
            E_MEPC:   state_nxt = E_MCAUSE;
            E_MCAUSE: state_nxt = E_MSTAT;
            E_MSTAT:  state_nxt = REDIR;
            M_MEPC:   state_nxt = M_MSTAT;
            M_MSTAT:  state_nxt = REDIR;
            REDIR:    if (redirect_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            // illegal ops are consumed in IDLE and only reported
            err_q <= accept && (req_op != OP_ECALL) && (req_op != OP_MRET);
            if (accept) req_q <= '{op: req_op, pc: req_pc};
            if (state == E_MCAUSE || state == M_MEPC)
                target_q <= {csr_rd_data[31:2], 2'b00};
        end
    end

    always_comb begin
        csr_rd_idx  = `MSTATUS;
        csr_wr_en   = 1'b0;
        csr_wr_idx  = 2'd0;
        csr_wr_data = 32'd0;
        case (state)
            E_MEPC: begin
                csr_wr_en   = 1'b1;
                csr_wr_idx  = `MEPC;
                csr_wr_data = {req_q.pc[31:2], 2'b00};
            end
            E_MCAUSE: begin
                csr_rd_idx  = `MTVEC;
                csr_wr_en   = 1'b1;
                csr_wr_idx  = `MCAUSE;
                csr_wr_data = CAUSE_ECALL;
            end
            E_MSTAT: begin
                csr_wr_en          = 1'b1;
                csr_wr_idx         = `MSTATUS;
                csr_wr_data        = csr_rd_data;
                csr_wr_data[7]     = csr_rd_data[3];
                csr_wr_data[3]     = 1'b0;
                csr_wr_data[12:11] = 2'b11;
            end
            M_MEPC: csr_rd_idx = `MEPC;
            M_MSTAT: begin
                csr_wr_en          = 1'b1;
                csr_wr_idx         = `MSTATUS;
                csr_wr_data        = csr_rd_data;
                csr_wr_data[3]     = csr_rd_data[7];
                csr_wr_data[7]     = 1'b1;
                csr_wr_data[12:11] = 2'b11;
            end
            default: ;
        endcase
    end

endmodule
